// File: rtl/avm_bridge_pkg.sv
// Shared types and defaults for the Wishbone-to-Avalon-MM bridge.
// Imported by the bridge top and its timeout counter.
package avm_bridge_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_ACK,
    RSP_ERR
  } rsp_e;

  localparam logic [31:0] DEF_BASE_ADDR      = 32'h9000_0000;
  localparam logic [31:0] DEF_ADDR_MASK      = 32'hFF00_0000;
  localparam int          DEF_TIMEOUT_CYCLES = 255;

  // Word-aligned byte offset of an address inside the decode window.
  function automatic logic [31:0] win_offset(input logic [31:0] adr,
                                             input logic [31:0] mask);
    logic [31:0] off;
    off = adr & ~mask;
    return {off[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts BUSY cycles; expired_o is high during the last allowed BUSY cycle.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module bus_timeout_cnt
  import avm_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Count holds (busy cycle index - 1), so expiry sits on the count TIMEOUT_CYCLES-1.
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last   = (cnt_q == LAST);
  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_last) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_avm_bridge.sv
// Single-outstanding Wishbone-to-Avalon-MM bridge with window decode,
// bus timeout and CPU-abort handling. All outputs are registered.
module wb_avm_bridge
  import avm_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK      = DEF_ADDR_MASK,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        avm_cs_o,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i
);

  // Handshakes: a Wishbone request is cyc&stb sampled in IDLE and answered by
  // exactly one ack or err pulse (none if cyc drops mid-transfer). An Avalon
  // transfer holds cs/read/write and payload until a cycle with waitrequest=0.
  state_e      state_q, state_d;
  rsp_e        rsp;
  logic        abort_q, abort_d;
  logic        abort_now;
  logic        hit;
  logic        expired;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  assign hit       = ((wb_adr_i & ADDR_MASK) == BASE_ADDR);
  assign abort_now = abort_q | ~wb_cyc_i;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_clk),
    .rst_i    (reset_reset),
    .enable_i (state_q == BUSY),
    .clear_i  (state_q == IDLE),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    rsp     = RSP_NONE;
    dat_d   = dat_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          if (hit) begin
            addr_d  = win_offset(wb_adr_i, ADDR_MASK);
            wdata_d = wb_dat_i;
            be_d    = wb_sel_i;
            cs_d    = 1'b1;
            rd_d    = ~wb_we_i;
            wr_d    = wb_we_i;
            state_d = BUSY;
          end else begin
            rsp = RSP_ERR;
          end
        end
      end
      BUSY: begin
        abort_d = abort_now;
        // Completion wins over a timeout landing in the same cycle.
        if (!avm_waitrequest_i) begin
          cs_d = 1'b0;
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (rd_q) begin
            dat_d = avm_readdata_i;
          end
          rsp     = abort_now ? RSP_NONE : RSP_ACK;
          abort_d = 1'b0;
          state_d = IDLE;
        end else if (expired) begin
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rsp     = abort_now ? RSP_NONE : RSP_ERR;
          abort_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = (rsp == RSP_ACK);
    err_d = (rsp == RSP_ERR);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign wb_dat_o         = dat_q;
  assign wb_ack_o         = ack_q;
  assign wb_err_o         = err_q;
  assign avm_cs_o         = cs_q;
  assign avm_read_o       = rd_q;
  assign avm_write_o      = wr_q;
  assign avm_address_o    = addr_q;
  assign avm_writedata_o  = wdata_q;
  assign avm_byteenable_o = be_q;

endmodule

// File: tb/tb_wb_avm_bridge.sv
// Bench for wb_avm_bridge: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model and a response scoreboard.
module tb_wb_avm_bridge;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam logic [31:0] MASK = 32'hFF00_0000;
  localparam int          TO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, wt;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic [31:0] wb_dat_o, avm_address_o, avm_writedata_o;
  logic        wb_ack_o, wb_err_o, avm_cs_o, avm_read_o, avm_write_o;
  logic [3:0]  avm_byteenable_o;

  int checks = 0;
  int errors = 0;

  // Model state: one transfer in flight, counted in BUSY cycles.
  bit          m_busy, m_abort, m_we;
  int          m_n;
  logic [31:0] e_dat, e_addr, e_wdata;
  logic [3:0]  e_be;
  logic        e_ack, e_err, e_cs, e_rd, e_wr;
  logic [33:0] exp_q[$];  // {ack, err, wb_dat}

  always #5 clk = ~clk;

  wb_avm_bridge #(
    .BASE_ADDR     (BASE),
    .ADDR_MASK     (MASK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .wb_cyc_i         (cyc),
    .wb_stb_i         (stb),
    .wb_we_i          (we),
    .wb_adr_i         (adr),
    .wb_dat_i         (wdat),
    .wb_sel_i         (sel),
    .wb_dat_o         (wb_dat_o),
    .wb_ack_o         (wb_ack_o),
    .wb_err_o         (wb_err_o),
    .avm_cs_o         (avm_cs_o),
    .avm_address_o    (avm_address_o),
    .avm_read_o       (avm_read_o),
    .avm_write_o      (avm_write_o),
    .avm_writedata_o  (avm_writedata_o),
    .avm_byteenable_o (avm_byteenable_o),
    .avm_waitrequest_i(wt),
    .avm_readdata_i   (rdat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_we = 0; m_n = 0;
    e_dat = '0; e_addr = '0; e_wdata = '0; e_be = '0;
    e_ack = 0; e_err = 0; e_cs = 0; e_rd = 0; e_wr = 0;
    exp_q.delete();
  endtask

  // Advances the model by one clock using the inputs applied this cycle.
  task automatic model_step();
    e_ack = 0;
    e_err = 0;
    if (!m_busy) begin
      if (cyc && stb) begin
        if ((adr & MASK) == BASE) begin
          e_cs = 1; e_rd = !we; e_wr = we;
          e_addr  = (adr - BASE) & 32'hFFFF_FFFC;
          e_wdata = wdat;
          e_be    = sel;
          m_busy = 1; m_n = 0; m_abort = 0; m_we = we;
        end else begin
          e_err = 1;
          exp_q.push_back({2'b01, e_dat});
        end
      end
    end else begin
      m_n++;
      if (!cyc) m_abort = 1;
      if (!wt) begin
        e_cs = 0; e_rd = 0; e_wr = 0;
        if (!m_we) e_dat = rdat;
        if (!m_abort) begin
          e_ack = 1;
          exp_q.push_back({2'b10, e_dat});
        end
        m_busy = 0;
      end else if (m_n == TO) begin
        e_cs = 0; e_rd = 0; e_wr = 0;
        if (!m_abort) begin
          e_err = 1;
          exp_q.push_back({2'b01, e_dat});
        end
        m_busy = 0;
      end
    end
  endtask

  task automatic compare();
    logic [33:0] r;
    chk("ack", 32'(wb_ack_o), 32'(e_ack));
    chk("err", 32'(wb_err_o), 32'(e_err));
    chk("cs", 32'(avm_cs_o), 32'(e_cs));
    chk("read", 32'(avm_read_o), 32'(e_rd));
    chk("write", 32'(avm_write_o), 32'(e_wr));
    chk("wb_dat", wb_dat_o, e_dat);
    if (e_cs) begin
      chk("address", avm_address_o, e_addr);
      chk("writedata", avm_writedata_o, e_wdata);
      chk("byteenable", 32'(avm_byteenable_o), 32'(e_be));
    end
    if (wb_ack_o || wb_err_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected response ack=%0b err=%0b", wb_ack_o, wb_err_o);
      end else begin
        r = exp_q.pop_front();
        chk("sb_resp", {30'd0, wb_ack_o, wb_err_o}, {30'd0, r[33:32]});
        chk("sb_dat", wb_dat_o, r[31:0]);
      end
    end
  endtask

  // Called at a negedge: applies inputs, clocks once, checks at the next negedge.
  task automatic step(input bit c, input bit s, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl, input bit wr,
                      input logic [31:0] rd);
    cyc = c; stb = s; we = w; adr = a; wdat = d; sel = sl; wt = wr; rdat = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit c, input bit wr, input logic [31:0] rd);
    for (int i = 0; i < n; i++) step(c, 0, 0, 32'h0, 32'h0, 4'h0, wr, rd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero_ctl"}, {26'd0, wb_ack_o, wb_err_o, avm_cs_o, avm_read_o, avm_write_o, 1'b0}, 32'h0);
    chk({tag, "_zero_dat"}, wb_dat_o, 32'h0);
    chk({tag, "_zero_addr"}, avm_address_o, 32'h0);
    chk({tag, "_zero_wdata"}, avm_writedata_o, 32'h0);
    chk({tag, "_zero_be"}, 32'(avm_byteenable_o), 32'h0);
  endtask

  initial begin
    int pct;
    logic [31:0] r;
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0; wt = 1; rdat = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;
    idle(2, 1, 1, 32'h0);

    // Write, zero wait states.
    step(1, 1, 1, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    chk("wr_cs", 32'(avm_cs_o), 32'd1);
    chk("wr_write", 32'(avm_write_o), 32'd1);
    chk("wr_addr", avm_address_o, 32'h0000_0010);
    chk("wr_wdata", avm_writedata_o, 32'hDEAD_BEEF);
    step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    chk("wr_ack", 32'(wb_ack_o), 32'd1);
    idle(2, 1, 1, 32'h0);

    // Read, three wait states.
    step(1, 1, 0, 32'h9012_3456, 32'h0, 4'hF, 1, 32'h0);
    chk("rd_addr", avm_address_o, 32'h0012_3454);
    idle(3, 1, 1, 32'hFFFF_0000);
    chk("rd_held", 32'(avm_read_o), 32'd1);
    step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h1234_5678);
    chk("rd_ack", 32'(wb_ack_o), 32'd1);
    chk("rd_dat", wb_dat_o, 32'h1234_5678);
    idle(2, 1, 1, 32'h0);

    // Window miss.
    step(1, 1, 0, 32'h8000_0000, 32'h0, 4'hF, 1, 32'h0);
    chk("miss_err", 32'(wb_err_o), 32'd1);
    chk("miss_cs", 32'(avm_cs_o), 32'd0);
    idle(2, 1, 1, 32'h0);

    // Timeout with waitrequest stuck high, then a normal transfer.
    step(1, 1, 1, 32'h9000_0100, 32'h5555_AAAA, 4'h3, 1, 32'h0);
    idle(TO - 1, 1, 1, 32'h0);
    chk("to_cs_held", 32'(avm_cs_o), 32'd1);
    idle(1, 1, 1, 32'h0);
    chk("to_cs_drop", 32'(avm_cs_o), 32'd0);
    chk("to_err", 32'(wb_err_o), 32'd1);
    idle(1, 1, 1, 32'h0);
    chk("to_err_once", 32'(wb_err_o), 32'd0);
    step(1, 1, 0, 32'h9000_0200, 32'h0, 4'hF, 0, 32'hA5A5_0001);
    step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'hA5A5_0001);
    chk("to_next_ack", 32'(wb_ack_o), 32'd1);

    // Abort: cyc dropped during BUSY, waitrequest released later.
    step(1, 1, 1, 32'h9000_0300, 32'h0BAD_F00D, 4'hF, 1, 32'h0);
    idle(4, 0, 1, 32'h0);
    chk("ab_cs_kept", 32'(avm_cs_o), 32'd1);
    idle(1, 0, 0, 32'h0);
    chk("ab_cs_done", 32'(avm_cs_o), 32'd0);
    chk("ab_no_ack", 32'(wb_ack_o), 32'd0);
    idle(2, 1, 1, 32'h0);

    // Asynchronous reset during BUSY.
    step(1, 1, 0, 32'h9000_0400, 32'h0, 4'hF, 1, 32'h0);
    idle(1, 1, 1, 32'h0);
    #2 rst = 1;
    #1 chk_all_zero("async");
    model_reset();
    @(negedge clk);
    rst = 0;
    idle(1, 1, 1, 32'h0);
    step(1, 1, 0, 32'h9000_0020, 32'h0, 4'hF, 1, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'hCAFE_F00D);
    chk("rst_rd_ack", 32'(wb_ack_o), 32'd1);
    chk("rst_rd_dat", wb_dat_o, 32'hCAFE_F00D);

    // Randomized traffic.
    pct = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 40;
          2: pct = 85;
          default: pct = 97;
        endcase
      end
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r[31:24] = 8'h90;
      else if (r[31:24] == 8'h90) r[31:24] = 8'h91;
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           r, $urandom(), 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < pct, $urandom());
    end
    idle(TO + 2, 1, 0, 32'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_avm_bridge.md
Name: wb_avm_bridge

Overview:
- Upstream neighbour of the Qsys SDRAM core. Converts NEORV32 external-bus (Wishbone-style) single transfers into Avalon-MM master transfers on the `avm_*` port of `qsys_core`.
- One transfer outstanding at a time. Provides address-window decode, response generation, a bus timeout, and safe handling of CPU-side aborts.

Parameters:
- BASE_ADDR, 32'h9000_0000: window base. A hit is `(wb_adr_i & ADDR_MASK) == BASE_ADDR`.
- ADDR_MASK, 32'hFF00_0000: address bits compared for decode.
- TIMEOUT_CYCLES, 255: maximum number of BUSY cycles before an error response. A value of 0 disables the timeout.

Ports:
- clk_clk  in  1  system clock, all logic rising-edge.
- reset_reset  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  request strobe (single-cycle pulse per request).
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- wb_ack_o  out  1  one-cycle success pulse.
- wb_err_o  out  1  one-cycle error pulse.
- avm_cs_o  out  1  Avalon chip select.
- avm_address_o  out  32  window offset, byte address.
- avm_read_o  out  1  Avalon read.
- avm_write_o  out  1  Avalon write.
- avm_writedata_o  out  32  Avalon write data.
- avm_byteenable_o  out  4  Avalon byte enables.
- avm_waitrequest_i  in  1  slave stall.
- avm_readdata_i  in  32  read data, valid in the read cycle where waitrequest = 0.

Behaviour:
- Reset (async, reset_reset = 1):
  - state = IDLE.
  - All outputs 0: wb_dat_o, wb_ack_o, wb_err_o, all avm_* outputs.
  - Timeout counter = 0, abort flag = 0.
- All outputs are registered. There is no combinational path from avm_waitrequest_i to wb_ack_o.
- IDLE:
  - On `wb_cyc_i & wb_stb_i` with a hit, latch the request:
    - avm_address_o = `{(wb_adr_i & ~ADDR_MASK)[31:2], 2'b00}`.
    - avm_writedata_o = wb_dat_i; avm_byteenable_o = wb_sel_i.
    - avm_cs_o = 1; avm_read_o = ~wb_we_i; avm_write_o = wb_we_i.
    - Go to BUSY.
  - On `wb_cyc_i & wb_stb_i` with a miss: wb_err_o = 1 for one cycle. No Avalon activity. Stay in IDLE.
  - stb without cyc is ignored.
- BUSY:
  - Avalon outputs are held stable while avm_waitrequest_i = 1.
  - On a cycle where avm_waitrequest_i = 0 is sampled:
    - Clear all avm_* control outputs to 0.
    - For a read, capture avm_readdata_i into wb_dat_o.
    - Next cycle: wb_ack_o = 1 for one cycle, unless the abort flag is set. Return to IDLE.
  - Counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), with waitrequest still 1:
    - Drop the avm_* controls.
    - wb_err_o = 1 next cycle, unless aborted. Return to IDLE.
  - A waitrequest = 0 in that same cycle takes priority: the response is ack, not err.
- Latency:
  - Request accepted in cycle 0; avm_* asserted in cycle 1.
  - waitrequest = 0 sampled in cycle N gives ack in cycle N+1.
  - Zero wait states gives ack in cycle 2.
- wb_dat_o holds its last read value until the next read completes. Writes do not change it.
- Abort: if wb_cyc_i = 0 during BUSY, set the abort flag.
  - The Avalon transfer still runs to completion or timeout; an Avalon transfer is never cut short.
  - No ack or err is issued for the aborted transfer.
  - The flag clears on return to IDLE.
- Request arriving in the same cycle as ack/err: state is IDLE in that cycle, so the request is accepted normally.
- wb_stb_i pulses while BUSY are ignored. The CPU guarantees a single outstanding request.

Decomposition:
- Shared package `avm_bridge_pkg`:
  - state enum {IDLE, BUSY}.
  - Response enum {RSP_NONE, RSP_ACK, RSP_ERR}.
  - Default window and timeout constants.
- One sub-module, `bus_timeout_cnt`:
  - Inputs: enable, clear.
  - Output: expired.
  - Width = `$clog2(TIMEOUT_CYCLES+1)`; expired is held low when TIMEOUT_CYCLES = 0.

Test Plan:
- Write, zero wait: stb with we = 1, adr = 9000_0010, dat = DEADBEEF, sel = F -> cycle 1: cs = 1, write = 1, address = 0000_0010, writedata = DEADBEEF, byteenable = F; cycle 2: ack = 1; err never asserted.
- Read, 3 wait states: adr = 9012_3456 -> address = 0012_3454, read held for 4 cycles; readdata = 1234_5678 sampled on release; ack and wb_dat_o = 1234_5678 one cycle later.
- Window miss: adr = 8000_0000 -> err = 1 on the next cycle; cs, read and write stay 0 throughout.
- Timeout: TIMEOUT_CYCLES = 8, waitrequest stuck at 1 -> controls drop after the 8th BUSY cycle; err pulses once; a following transfer completes normally with ack.
- Abort: cyc dropped during BUSY, waitrequest released 5 cycles later -> Avalon write completes; neither ack nor err is ever asserted.
- Reset mid-transfer: reset_reset = 1 during BUSY -> all outputs 0 immediately (asynchronously); after release, a new read gives a correct ack.
